// File: rtl/dt_pkg.sv
// Shared types and constants for the parametrised two-pass distance-transform engine.
package dt_pkg;

    typedef enum logic [3:0] {
        FW_FETCH,
        FW_PIX,
        FW_RD,
        FW_WR,
        FW_END,
        BW_RDP,
        BW_RD,
        BW_WR,
        DONE
    } state_t;

    localparam logic METRIC_CHESS = 1'b0;
    localparam logic METRIC_CITY  = 1'b1;

    // Neighbour offsets: forward {NW, N, NE, W}, backward {E, SW, S, SE}
    localparam int FW_DR [4] = '{-1, -1, -1,  0};
    localparam int FW_DC [4] = '{-1,  0,  1, -1};
    localparam int BW_DR [4] = '{ 0,  1,  1,  1};
    localparam int BW_DC [4] = '{ 1, -1,  0,  1};

    function automatic int width_of(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int pix_addr_w(input int w, input int h);
        return width_of(w * h);
    endfunction

    function automatic int word_addr_w(input int w, input int h, input int s);
        return width_of((w * h) / s);
    endfunction

    // City-block keeps only the orthogonal neighbours of each pass
    function automatic logic [3:0] nb_mask(input logic metric, input logic bwd);
        if (metric == METRIC_CHESS) begin
            return 4'b1111;
        end
        return bwd ? 4'b0101 : 4'b1010;
    endfunction

endpackage

// File: rtl/dt_min_sat.sv
// Masked minimum over four distance operands, plus one, clamped to the largest distance.
module dt_min_sat #(
    parameter int DIST_W = 8
) (
    input  logic [4*DIST_W-1:0] ops,
    input  logic [3:0]          mask,
    output logic [DIST_W-1:0]   min_p1
);

    logic [DIST_W-1:0] m;
    logic [DIST_W:0]   sum;

    always_comb begin
        m = '1;
        for (int k = 0; k < 4; k++) begin
            if (mask[k] && (ops[k*DIST_W +: DIST_W] < m)) begin
                m = ops[k*DIST_W +: DIST_W];
            end
        end
        sum    = {1'b0, m} + (DIST_W+1)'(1);
        min_p1 = sum[DIST_W] ? '1 : sum[DIST_W-1:0];
    end

endmodule

// File: rtl/dt_engine_param.sv
// Two-pass chessboard / city-block distance transform from a packed binary ROM image into a result RAM.
module dt_engine_param
    import dt_pkg::*;
#(
    parameter int IMG_W  = 128,
    parameter int IMG_H  = 128,
    parameter int STI_W  = 16,
    parameter int DIST_W = 8,
    localparam int SA = word_addr_w(IMG_W, IMG_H, STI_W),
    localparam int RA = pix_addr_w(IMG_W, IMG_H)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              metric,
    output logic              sti_rd,
    output logic [SA-1:0]     sti_addr,
    input  logic [STI_W-1:0]  sti_di,
    output logic              res_rd,
    output logic              res_wr,
    output logic [RA-1:0]     res_addr,
    output logic [DIST_W-1:0] res_do,
    input  logic [DIST_W-1:0] res_di,
    output logic              fwpass_finish,
    output logic              done
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = RA - CW;
    localparam int BC = width_of(STI_W);

    state_t             state, state_nx;
    logic               run, metric_q;
    logic [RW-1:0]      row;
    logic [CW-1:0]      col;
    logic [SA-1:0]      word_idx;
    logic [BC-1:0]      bit_cnt;
    logic [STI_W-1:0]   sti_sr;
    logic [1:0]         k;
    logic [DIST_W-1:0]  nb_val [4];
    logic [3:0]         nb_en;
    logic [DIST_W-1:0]  w_hold, e_hold, p_val;
    logic [RA-1:0]      addr_q, addr_c, cur_addr, nb_addr;
    logic [DIST_W-1:0]  do_q, do_c;
    logic               fw_q, done_q;

    logic               bwd, pix, first_pix, last_pix, word_end, nb_in, nb_used;
    logic [3:0]         mask;
    int                 nr, nc;
    logic [DIST_W-1:0]  side_op, sat, fw_val, bw_val;
    logic [4*DIST_W-1:0] ops;
    logic [3:0]         ops_mask;

    assign bwd       = (state == BW_RDP) || (state == BW_RD) || (state == BW_WR);
    assign pix       = sti_sr[STI_W-1];
    assign first_pix = (row == '0) && (col == '0);
    assign last_pix  = (row == RW'(IMG_H-1)) && (col == CW'(IMG_W-1));
    assign word_end  = (bit_cnt == BC'(STI_W-1));
    assign cur_addr  = {row, col};
    assign mask      = nb_mask(metric_q, bwd);
    assign nb_used   = mask[k];

    // Address of the neighbour selected by k; cells outside the image read as distance 0
    always_comb begin
        nr = int'(row) + (bwd ? BW_DR[k] : FW_DR[k]);
        nc = int'(col) + (bwd ? BW_DC[k] : FW_DC[k]);
        nb_in   = (nr >= 0) && (nr < IMG_H) && (nc >= 0) && (nc < IMG_W);
        nb_addr = {nr[RW-1:0], nc[CW-1:0]};
    end

    // W (forward) or E (backward) comes from the hold register instead of a RAM read
    always_comb begin
        if (bwd) begin
            side_op  = (col == CW'(IMG_W-1)) ? '0 : e_hold;
            ops      = {nb_val[3], nb_val[2], nb_val[1], side_op};
            ops_mask = {nb_en[3:1], 1'b1};
        end else begin
            side_op  = (col == '0) ? '0 : w_hold;
            ops      = {side_op, nb_val[2], nb_val[1], nb_val[0]};
            ops_mask = {1'b1, nb_en[2:0]};
        end
    end

    dt_min_sat #(.DIST_W(DIST_W)) u_min_sat (
        .ops    (ops),
        .mask   (ops_mask),
        .min_p1 (sat)
    );

    assign fw_val = pix ? sat : '0;
    assign bw_val = (p_val < sat) ? p_val : sat;

    always_comb begin
        state_nx = state;
        sti_rd   = 1'b0;
        res_rd   = 1'b0;
        res_wr   = 1'b0;
        addr_c   = addr_q;
        do_c     = do_q;
        case (state)
            FW_FETCH: begin
                if (run) begin
                    sti_rd   = 1'b1;
                    state_nx = FW_PIX;
                end
            end
            FW_PIX: state_nx = pix ? FW_RD : FW_WR;
            FW_RD: begin
                if (nb_used && nb_in) begin
                    res_rd = 1'b1;
                    addr_c = nb_addr;
                end
                if (k == 2'd2) state_nx = FW_WR;
            end
            FW_WR: begin
                res_wr = 1'b1;
                addr_c = cur_addr;
                do_c   = fw_val;
                if (last_pix)      state_nx = FW_END;
                else if (word_end) state_nx = FW_FETCH;
                else               state_nx = FW_PIX;
            end
            FW_END: state_nx = BW_RDP;
            BW_RDP: begin
                res_rd = 1'b1;
                addr_c = cur_addr;
                if (res_di != '0) state_nx = BW_RD;
                else              state_nx = first_pix ? DONE : BW_RDP;
            end
            BW_RD: begin
                if (nb_used && nb_in) begin
                    res_rd = 1'b1;
                    addr_c = nb_addr;
                end
                if (k == 2'd3) state_nx = BW_WR;
            end
            BW_WR: begin
                res_wr   = 1'b1;
                addr_c   = cur_addr;
                do_c     = bw_val;
                state_nx = first_pix ? DONE : BW_RDP;
            end
            DONE:    state_nx = DONE;
            default: state_nx = FW_FETCH;
        endcase
    end

    assign res_addr      = addr_c;
    assign res_do        = do_c;
    assign sti_addr      = word_idx;
    assign fwpass_finish = fw_q;
    assign done          = done_q;

    // run gates the first fetch so nothing is strobed until metric has been captured
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= FW_FETCH;
            run      <= 1'b0;
            metric_q <= METRIC_CHESS;
            row      <= '0;
            col      <= '0;
            word_idx <= '0;
            bit_cnt  <= '0;
            sti_sr   <= '0;
            k        <= '0;
            for (int i = 0; i < 4; i++) nb_val[i] <= '0;
            nb_en    <= '0;
            w_hold   <= '0;
            e_hold   <= '0;
            p_val    <= '0;
            addr_q   <= '0;
            do_q     <= '0;
            fw_q     <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state  <= state_nx;
            addr_q <= addr_c;
            do_q   <= do_c;
            if (!run) begin
                run      <= 1'b1;
                metric_q <= metric;
            end
            case (state)
                FW_FETCH: begin
                    if (run) begin
                        sti_sr  <= sti_di;
                        bit_cnt <= '0;
                    end
                end
                FW_PIX: k <= 2'd0;
                FW_RD, BW_RD: begin
                    nb_en[k]  <= nb_used;
                    nb_val[k] <= (nb_used && nb_in) ? res_di : '0;
                    k         <= k + 2'd1;
                end
                FW_WR: begin
                    w_hold  <= fw_val;
                    sti_sr  <= sti_sr << 1;
                    bit_cnt <= bit_cnt + BC'(1);
                    if (last_pix) begin
                        fw_q <= 1'b1;
                    end else begin
                        if (word_end) word_idx <= word_idx + SA'(1);
                        if (col == CW'(IMG_W-1)) row <= row + RW'(1);
                        col <= col + CW'(1);
                    end
                end
                BW_RDP: begin
                    p_val <= res_di;
                    k     <= 2'd1;
                    if (res_di == '0) begin
                        e_hold <= '0;
                        if (first_pix) begin
                            done_q <= 1'b1;
                        end else begin
                            if (col == '0) row <= row - RW'(1);
                            col <= col - CW'(1);
                        end
                    end
                end
                BW_WR: begin
                    e_hold <= bw_val;
                    if (first_pix) begin
                        done_q <= 1'b1;
                    end else begin
                        if (col == '0) row <= row - RW'(1);
                        col <= col - CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
